spi_xfer_ctrl: RTL and testbench
================================

Name: spi_xfer_ctrl

Overview:
Byte-stream controller sitting directly upstream of the SPI byte engine `spi`. It buffers outgoing bytes in a TX FIFO and launches one engine transfer per byte using the engine's ready_send/busy handshake. It captures each received byte into an RX FIFO. It presents valid/ready streams to the processor side, so software never polls the engine directly.

Parameters:
DEPTH, 8, entries per FIFO; power of two, >=2.
START_TIMEOUT, 4, max clk cycles from ready_send pulse to busy rise before the start is declared failed; >=1.

Ports:
clk  in  1  processor clock
rst_n  in  1  asynchronous, active-low reset
tx_data  in  8  byte to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX FIFO not full
rx_data  out  8  received byte (head of RX FIFO)
rx_valid  out  1  RX FIFO not empty
rx_ready  in  1  consumer accepts rx_data
tx_count  out  $clog2(DEPTH)+1  TX FIFO occupancy
rx_count  out  $clog2(DEPTH)+1  RX FIFO occupancy
idle  out  1  FSM in IDLE and TX FIFO empty
start_err  out  1  sticky: an engine start timed out
clr_err  in  1  clears start_err
spi_data_in  out  8  to engine data_in
spi_ready_send  out  1  to engine ready_send
spi_busy  in  1  from engine busy
spi_data_out  in  8  from engine data_out

Behaviour:
- Reset (rst_n low, async): both FIFOs empty, pointers 0, FSM=IDLE, spi_ready_send=0, spi_data_in=0, start_err=0, timeout counter=0.
- Reset resulting outputs: tx_ready=1, rx_valid=0, idle=1.
- Reset mid-transfer aborts immediately; FIFO contents are discarded; no byte is captured.
- TX push: when tx_valid && tx_ready. A push to a full FIFO is impossible because tx_ready=0 when full.
- RX pop: when rx_valid && rx_ready.
- Occupancy counts: count = wr_ptr - rd_ptr, using pointers one bit wider than the address, wrapping modulo 2*DEPTH. Full when count==DEPTH; empty when count==0.
- Simultaneous push and pop on the same FIFO in one cycle is legal. Count is unchanged; a pop from an empty FIFO cannot occur.
- rx_data is the registered FIFO head, valid in the same cycle rx_valid is high (first-word-fall-through).
- FSM states and transitions:
  - IDLE: if TX non-empty && rx_count<DEPTH && !spi_busy, go to LOAD.
  - LOAD (1 cycle): spi_data_in <= TX head; spi_ready_send=1; TX pop; timeout counter cleared; go to WAIT_BUSY.
  - WAIT_BUSY: spi_ready_send=0; spi_data_in is held.
    - If spi_busy=1, go to XFER.
    - Else, on counter==START_TIMEOUT-1: set start_err, go to IDLE. The byte is lost and nothing is pushed to RX.
    - Otherwise the counter increments.
  - XFER: wait for spi_busy=0, then go to CAPTURE.
  - CAPTURE (1 cycle): push spi_data_out into RX, go to IDLE.
- Back-to-back: minimum gap between the engine's busy fall and the next ready_send is 2 cycles (CAPTURE, IDLE). No pipelining of transfers.
- The RX room check happens in IDLE only. Only one transfer is ever in flight, and RX can only shrink meanwhile, so the CAPTURE push never overflows.
- A CAPTURE push coinciding with an RX pop is legal (see simultaneous push/pop above).
- start_err: set in WAIT_BUSY timeout; cleared by clr_err. If set and clear happen in the same cycle, set wins.
- tx_count/rx_count/idle are combinational from registered state.

Decomposition:
- Shared package spi_pkg: byte width constant (8), FSM state enum (IDLE, LOAD, WAIT_BUSY, XFER, CAPTURE).
- One sub-module: spi_byte_fifo, parameterised on DEPTH.
  - Ports: clk, rst_n, wr_en, wr_data, rd_en, rd_data, count, full, empty.
  - Instantiated twice, once for TX and once for RX.

Test Plan:
- Single byte: push 0xA5; engine model asserts busy 2 cycles after ready_send, holds it 64 cycles, returns 0x3C. Expect:
  - spi_data_in=0xA5 and a single-cycle spi_ready_send;
  - rx_valid with rx_data=0x3C exactly 1 cycle after CAPTURE;
  - idle=1 afterwards.
- Burst: push 0x01..0x08 back-to-back (DEPTH=8). Expect:
  - tx_ready low after the 8th push;
  - 8 ready_send pulses in order;
  - RX returns the model's echo bytes in order;
  - counts track to 0 and 8.
- RX backpressure: hold rx_ready=0, send 9 bytes. Expect:
  - exactly 8 transfers, with the FSM parked in IDLE and tx_count=1;
  - after one pop, the 9th transfer starts within 2 cycles.
- Start timeout: engine model never raises busy. Expect:
  - start_err=1 exactly START_TIMEOUT cycles after the ready_send pulse;
  - no RX push; FSM back in IDLE;
  - clr_err clears start_err; set wins over a simultaneous clear.
- Reset mid-XFER: push 0x55, deassert rst_n while busy=1. Expect:
  - all outputs at reset values immediately (asynchronous);
  - after release, tx_count=0 and rx_count=0 and no ready_send.
- Simultaneous push/pop: with RX holding 3 bytes, a CAPTURE coinciding with an RX pop leaves rx_count=3 and preserves order.

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI byte-stream controller: byte width, byte
// type and the transfer FSM state encoding.
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  // IDLE      : waiting for a TX byte, RX room and a quiet engine
  // LOAD      : one-cycle ready_send pulse, TX head handed to the engine
  // WAIT_BUSY : waiting for the engine to acknowledge with busy
  // XFER      : engine shifting, waiting for busy to fall
  // CAPTURE   : one-cycle push of the received byte into RX
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    XFER,
    CAPTURE
  } xfer_state_e;

endpackage

// File: rtl/spi_byte_fifo.sv
// -----------------------------------------------------------------------------
// spi_byte_fifo
// Byte-wide synchronous FIFO with first-word-fall-through read: rd_data always
// shows the entry at the read pointer, so it is valid whenever empty is low.
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   wr_en      : push wr_data (ignored when full)
//   wr_data    : byte to push
//   rd_en      : pop the head (ignored when empty)
//   rd_data    : current head byte
//   count      : occupancy, 0..DEPTH
//   full       : count == DEPTH
//   empty      : count == 0
// -----------------------------------------------------------------------------
module spi_byte_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [BYTE_W-1:0]      wr_data,
  input  logic                   rd_en,
  output logic [BYTE_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  byte_t       mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        wr_fire;
  logic        rd_fire;

  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;

  // Pointers carry one extra bit so that full and empty stay distinguishable
  // when the address bits are equal.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // has been written, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/spi_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// spi_xfer_ctrl
// Byte-stream front end for the SPI byte engine. Outgoing bytes are queued in
// a TX FIFO and launched one at a time with the engine's ready_send/busy
// handshake; each received byte is queued in an RX FIFO. Only one transfer is
// ever in flight.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   tx_data/valid  : processor byte stream in; tx_ready = TX FIFO not full
//   rx_data/valid  : received byte stream out (FWFT); rx_ready = consumer pop
//   tx_count       : TX FIFO occupancy
//   rx_count       : RX FIFO occupancy
//   idle           : FSM idle and nothing queued for transmit
//   start_err      : sticky, an engine start timed out; clr_err clears it
//   spi_data_in    : byte handed to the engine
//   spi_ready_send : one-cycle start pulse to the engine
//   spi_busy       : engine busy
//   spi_data_out   : byte received by the engine
// -----------------------------------------------------------------------------
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int START_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [BYTE_W-1:0]      tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [BYTE_W-1:0]      rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic [$clog2(DEPTH):0] tx_count,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic                   idle,
  output logic                   start_err,
  input  logic                   clr_err,
  output logic [BYTE_W-1:0]      spi_data_in,
  output logic                   spi_ready_send,
  input  logic                   spi_busy,
  input  logic [BYTE_W-1:0]      spi_data_out
);

  localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  xfer_state_e   state;
  logic [TW-1:0] tmo_cnt;

  byte_t tx_head;
  logic  tx_full;
  logic  tx_empty;
  logic  tx_rd_en;
  logic  rx_full;
  logic  rx_empty;
  logic  rx_wr_en;

  // ---------------------------------------------------------------------------
  // FIFOs
  // ---------------------------------------------------------------------------
  assign tx_rd_en = (state == LOAD);
  assign rx_wr_en = (state == CAPTURE);

  spi_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (tx_valid && tx_ready),
    .wr_data (tx_data),
    .rd_en   (tx_rd_en),
    .rd_data (tx_head),
    .count   (tx_count),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  spi_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (rx_wr_en),
    .wr_data (spi_data_out),
    .rd_en   (rx_valid && rx_ready),
    .rd_data (rx_data),
    .count   (rx_count),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;
  assign idle     = (state == IDLE) && tx_empty;

  // ---------------------------------------------------------------------------
  // Transfer FSM with registered engine outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      spi_ready_send <= 1'b0;
      spi_data_in    <= '0;
      start_err      <= 1'b0;
      tmo_cnt        <= '0;
    end else begin
      // A timeout set later in this block overrides a same-cycle clear.
      if (clr_err) start_err <= 1'b0;

      unique case (state)
        IDLE: begin
          // RX room is checked only here: with one transfer in flight and RX
          // only draining meanwhile, the later CAPTURE push always fits.
          if (!tx_empty && !rx_full && !spi_busy) begin
            // Byte and pulse are registered on entry so that both are
            // presented to the engine during the LOAD cycle itself.
            spi_data_in    <= tx_head;
            spi_ready_send <= 1'b1;
            state          <= LOAD;
          end
        end

        LOAD: begin
          spi_ready_send <= 1'b0;
          tmo_cnt        <= '0;
          state          <= WAIT_BUSY;
        end

        WAIT_BUSY: begin
          if (spi_busy) begin
            state <= XFER;
          end else if (tmo_cnt == TW'(START_TIMEOUT - 1)) begin
            // The byte is dropped; nothing reaches RX.
            start_err <= 1'b1;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        XFER: begin
          if (!spi_busy) state <= CAPTURE;
        end

        CAPTURE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_xfer_ctrl
// Self-checking bench for spi_xfer_ctrl. A behavioural engine answers every
// ready_send with busy after a programmable delay and returns data_in ^ 8'h99.
// Directed vectors cover single transfers, burst, RX backpressure, start
// timeout, asynchronous reset and simultaneous push/pop; a randomized phase
// compares the RX stream against a queue model of the byte stream.
// -----------------------------------------------------------------------------
module tb_spi_xfer_ctrl;
  import spi_pkg::*;

  localparam int DEPTH = 8;
  localparam int T     = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  byte_t         tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  byte_t         rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic [CW-1:0] tx_count;
  logic [CW-1:0] rx_count;
  logic          idle;
  logic          start_err;
  logic          clr_err = 1'b0;
  byte_t         spi_data_in;
  logic          spi_ready_send;
  logic          spi_busy;
  byte_t         spi_data_out;

  // Engine busy plus a bench-side hold that keeps the controller parked.
  logic eng_busy  = 1'b0;
  logic hold_busy = 1'b0;
  assign spi_busy = eng_busy | hold_busy;

  spi_xfer_ctrl #(.DEPTH(DEPTH), .START_TIMEOUT(T)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .tx_count       (tx_count),
    .rx_count       (rx_count),
    .idle           (idle),
    .start_err      (start_err),
    .clr_err        (clr_err),
    .spi_data_in    (spi_data_in),
    .spi_ready_send (spi_ready_send),
    .spi_busy       (spi_busy),
    .spi_data_out   (spi_data_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic byte_t echo(input byte_t b);
    return b ^ 8'h99;
  endfunction

  // ---------------------------------------------------------------------------
  // Engine model
  // ---------------------------------------------------------------------------
  logic eng_on    = 1'b1;
  int   eng_delay = 2;
  int   eng_len   = 64;

  initial begin
    byte_t b;
    int    d;
    int    l;
    spi_data_out = '0;
    forever begin
      @(negedge clk);
      if (rst_n && eng_on && spi_ready_send) begin
        b = spi_data_in;
        d = eng_delay;
        l = eng_len;
        @(posedge clk);
        for (int i = 1; i < d; i++) @(posedge clk);
        #1 eng_busy = 1'b1;
        for (int i = 0; i < l && rst_n; i++) @(posedge clk);
        #1;
        eng_busy     = 1'b0;
        spi_data_out = echo(b);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Passive monitor of the engine interface
  // ---------------------------------------------------------------------------
  int          rs_pulses = 0;
  int          rs_long   = 0;
  logic        rs_prev   = 1'b0;
  logic        busy_prev = 1'b0;
  int unsigned rs_fall_cyc   = 0;
  int unsigned busy_fall_cyc = 0;
  byte_t       sent_q[$];

  always @(negedge clk) begin
    if (spi_ready_send && !rs_prev) begin
      rs_pulses++;
      sent_q.push_back(spi_data_in);
    end
    if (spi_ready_send && rs_prev) rs_long++;
    if (!spi_ready_send && rs_prev) rs_fall_cyc = cyc;
    if (!spi_busy && busy_prev) busy_fall_cyc = cyc;
    rs_prev   = spi_ready_send;
    busy_prev = spi_busy;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: every step lands just after a falling edge
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input byte_t b);
    int n = 0;
    while (!tx_ready && n < 400) begin
      step();
      n++;
    end
    check("push_tx_ready", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
  endtask

  task automatic pop(output byte_t b);
    check("pop_rx_valid", rx_valid, 1);
    b        = rx_data;
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
  endtask

  task automatic wait_rx_count(input int target, input string name);
    int n = 0;
    while (rx_count != CW'(target) && n < 2000) begin
      step();
      n++;
    end
    check(name, rx_count, target);
  endtask

  // ---------------------------------------------------------------------------
  // Directed single-transfer vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    byte_t tx;
    int    dly;
    int    len;
    byte_t exp_rx;
  } vec_t;

  vec_t  vecs[5];
  byte_t exp_q[$];

  initial begin
    int    n;
    int    p0;
    int    q0;
    int    pushed;
    int    popped;
    byte_t b;
    byte_t s;

    vecs[0] = '{8'hA5, 2, 64, 8'h3C};
    vecs[1] = '{8'h00, 1, 1,  8'h99};
    vecs[2] = '{8'hFF, 4, 5,  8'h66};
    vecs[3] = '{8'h5A, 3, 20, 8'hC3};
    vecs[4] = '{8'h99, 2, 3,  8'h00};

    // ---- reset state ----
    step();
    step();
    check("rst_tx_ready",   tx_ready, 1);
    check("rst_rx_valid",   rx_valid, 0);
    check("rst_idle",       idle, 1);
    check("rst_ready_send", spi_ready_send, 0);
    check("rst_data_in",    spi_data_in, 0);
    check("rst_start_err",  start_err, 0);
    check("rst_tx_count",   tx_count, 0);
    check("rst_rx_count",   rx_count, 0);
    rst_n = 1'b1;
    step();

    // ---- single transfers ----
    for (int v = 0; v < 5; v++) begin
      eng_delay = vecs[v].dly;
      eng_len   = vecs[v].len;
      p0 = rs_pulses;
      q0 = sent_q.size();
      push(vecs[v].tx);
      n = 0;
      while (!rx_valid && n < 300) begin
        step();
        n++;
      end
      check("vec_rx_valid", rx_valid, 1);
      check("vec_capture_latency", cyc - busy_fall_cyc, 2);
      check("vec_rx_data", rx_data, vecs[v].exp_rx);
      check("vec_pulse_count", rs_pulses - p0, 1);
      check("vec_pulse_width", rs_long, 0);
      s = (sent_q.size() > q0) ? sent_q[q0] : 8'hxx;
      check("vec_spi_data_in", s, vecs[v].tx);
      pop(b);
      check("vec_idle_after", idle, 1);
      check("vec_rx_empty_after", rx_valid, 0);
    end

    // ---- burst of DEPTH bytes with the controller parked ----
    hold_busy = 1'b1;
    eng_delay = 2;
    eng_len   = 6;
    p0 = rs_pulses;
    q0 = sent_q.size();
    for (int i = 0; i < DEPTH; i++) push(byte_t'(i + 1));
    check("burst_tx_ready_full", tx_ready, 0);
    check("burst_tx_count_full", tx_count, DEPTH);
    check("burst_rx_count_zero", rx_count, 0);
    hold_busy = 1'b0;
    wait_rx_count(DEPTH, "burst_rx_count_full");
    check("burst_pulses", rs_pulses - p0, DEPTH);
    check("burst_tx_count_zero", tx_count, 0);
    check("burst_tx_ready_again", tx_ready, 1);
    for (int i = 0; i < DEPTH; i++) begin
      s = (sent_q.size() > q0 + i) ? sent_q[q0 + i] : 8'hxx;
      check("burst_send_order", s, i + 1);
    end
    for (int i = 0; i < DEPTH; i++) begin
      pop(b);
      check("burst_rx_order", b, echo(byte_t'(i + 1)));
    end
    check("burst_rx_count_drained", rx_count, 0);

    // ---- RX backpressure ----
    eng_len = 4;
    p0 = rs_pulses;
    for (int i = 0; i <= DEPTH; i++) push(byte_t'(8'h10 + i));
    wait_rx_count(DEPTH, "bp_rx_count_full");
    repeat (30) step();
    check("bp_pulses", rs_pulses - p0, DEPTH);
    check("bp_tx_count", tx_count, 1);
    check("bp_rx_count", rx_count, DEPTH);
    check("bp_not_idle", idle, 0);
    pop(b);
    check("bp_first_byte", b, echo(8'h10));
    n = 1;
    while (!spi_ready_send && n < 10) begin
      step();
      n++;
    end
    check("bp_restart_within_2", n <= 2, 1);
    wait_rx_count(DEPTH, "bp_rx_refill");
    for (int i = 1; i <= DEPTH; i++) begin
      pop(b);
      check("bp_rx_order", b, echo(byte_t'(8'h10 + i)));
    end

    // ---- start timeout ----
    eng_on = 1'b0;
    p0 = rs_pulses;
    push(8'h77);
    n = 0;
    while (!start_err && n < 50) begin
      step();
      n++;
    end
    check("tmo_start_err_set", start_err, 1);
    check("tmo_latency", cyc - rs_fall_cyc, T);
    check("tmo_one_pulse", rs_pulses - p0, 1);
    check("tmo_no_rx_push", rx_count, 0);
    check("tmo_rx_valid", rx_valid, 0);
    check("tmo_idle", idle, 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("tmo_clr", start_err, 0);
    // clr_err held high across the whole second timeout: the set must win
    clr_err = 1'b1;
    push(8'h78);
    n = 0;
    while (!start_err && n < 50) begin
      step();
      n++;
    end
    check("tmo_set_beats_clr", start_err, 1);
    step();
    check("tmo_clr_next_cycle", start_err, 0);
    clr_err = 1'b0;
    eng_on  = 1'b1;

    // ---- reset in the middle of a transfer ----
    eng_delay = 2;
    eng_len   = 40;
    push(8'h55);
    n = 0;
    while (!spi_busy && n < 20) begin
      step();
      n++;
    end
    check("rstx_busy_seen", spi_busy, 1);
    repeat (3) step();
    check("rstx_data_in_before", spi_data_in, 8'h55);
    #2 rst_n = 1'b0;
    #1;
    check("rstx_tx_ready",   tx_ready, 1);
    check("rstx_rx_valid",   rx_valid, 0);
    check("rstx_idle",       idle, 1);
    check("rstx_ready_send", spi_ready_send, 0);
    check("rstx_data_in",    spi_data_in, 0);
    check("rstx_start_err",  start_err, 0);
    step();
    step();
    rst_n = 1'b1;
    p0 = rs_pulses;
    repeat (50) step();
    check("rstx_no_pulse",  rs_pulses - p0, 0);
    check("rstx_tx_count",  tx_count, 0);
    check("rstx_rx_count",  rx_count, 0);
    check("rstx_rx_valid2", rx_valid, 0);

    // ---- CAPTURE push coinciding with an RX pop ----
    eng_len = 3;
    push(8'h21);
    push(8'h22);
    push(8'h23);
    wait_rx_count(3, "sim_rx_count_3");
    eng_len = 10;
    push(8'h24);
    n = 0;
    while (!spi_busy && n < 20) begin
      step();
      n++;
    end
    n = 0;
    while (spi_busy && n < 40) begin
      step();
      n++;
    end
    step();  // CAPTURE cycle
    check("sim_count_before", rx_count, 3);
    b        = rx_data;
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    check("sim_count_after", rx_count, 3);
    check("sim_popped", b, echo(8'h21));
    for (int i = 2; i <= 4; i++) begin
      pop(b);
      check("sim_order", b, echo(byte_t'(8'h20 + i)));
    end
    check("sim_drained", rx_count, 0);

    // ---- randomized stream against the queue model ----
    pushed = 0;
    popped = 0;
    exp_q.delete();
    for (int k = 0; k < 3000; k++) begin
      if (k % 50 == 0) begin
        eng_delay = $urandom_range(1, T);
        eng_len   = $urandom_range(1, 12);
      end
      tx_valid = (k < 2500) && ($urandom_range(0, 3) != 0);
      tx_data  = 8'($urandom);
      rx_ready = ($urandom_range(0, 2) != 0);
      if (tx_valid && tx_ready) begin
        exp_q.push_back(echo(tx_data));
        pushed++;
      end
      if (rx_valid && rx_ready) begin
        s = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check("rand_rx_data", rx_data, s);
        popped++;
      end
      step();
    end
    tx_valid = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      rx_ready = 1'b1;
      if (rx_valid) begin
        s = exp_q.pop_front();
        check("rand_drain_data", rx_data, s);
        popped++;
      end
      step();
      n++;
    end
    rx_ready = 1'b0;
    step();
    check("rand_all_returned", popped, pushed);
    check("rand_no_start_err", start_err, 0);
    check("rand_tx_empty", tx_count, 0);
    check("rand_rx_empty", rx_count, 0);
    check("rand_idle", idle, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
